// File: rtl/word_byte_ser_if.sv
// word_byte_ser_if: word-in / byte-out handshake bundle for the word serializer.
interface word_byte_ser_if;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_short;
  logic [7:0]  word_count;
  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_byte, out_valid, out_last, out_short, word_count
  );
  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_byte, out_valid, out_last, out_short, word_count
  );
endinterface

// File: rtl/word_byte_ser.sv
// word_byte_ser: serializes 16-bit words into low-then-high bytes, optionally
// dropping a zero upper byte so the receiver can zero-extend.
module word_byte_ser #(
  parameter bit COMPRESS = 1'b1
) (
  input logic            clk,
  input logic            reset,
  word_byte_ser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_word;
  logic        r_short;
  logic [7:0]  r_count;
  logic        w_in_hs, w_out_hs, w_last;
  assign w_in_hs  = bus.in_valid && r_state == IDLE;
  assign w_out_hs = bus.out_ready && (r_state == SEND_LO || r_state == SEND_HI);
  assign w_last   = r_state == SEND_HI || (r_state == SEND_LO && r_short);
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE ? (bus.in_valid ? SEND_LO : IDLE)
           : !bus.out_ready  ? r_state
           : (r_state == SEND_LO && !r_short) ? SEND_HI : IDLE;
  end
  // The short decision is frozen at latch time so later in_word changes cannot alter it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word  <= 16'h0000;
      r_short <= 1'b0;
      r_count <= 8'h00;
    end else begin
      if (w_in_hs) begin
        r_word  <= bus.in_word;
        r_short <= COMPRESS && bus.in_word[15:8] == 8'h00;
      end
      if (w_out_hs && w_last) r_count <= r_count + 8'h01;
    end
  end
  always_comb begin
    bus.in_ready   = r_state == IDLE;
    bus.out_valid  = r_state == SEND_LO || r_state == SEND_HI;
    bus.out_byte   = r_state == SEND_LO ? r_word[7:0] : r_state == SEND_HI ? r_word[15:8] : 8'h00;
    bus.out_last   = w_last;
    bus.out_short  = r_state == SEND_LO && r_short;
    bus.word_count = r_count;
  end
endmodule

// File: doc/word_byte_ser.md
WORD_BYTE_SER -- requirements
Module: word_byte_ser

Interface
- REQ-001: Parameter COMPRESS, default 1, meaning: when 1, a word with upper byte 8'h00 SHALL be sent as a single byte (inverse of 8b->16b zero extension); when 0, every word SHALL be sent as two bytes.
- REQ-002: clk  input  1  system clock; all state SHALL update on the rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- REQ-004: in_word  input  16  word to be serialized.
- REQ-005: in_valid  input  1  in_word is valid.
- REQ-006: in_ready  output  1  block can accept a word this cycle.
- REQ-007: out_byte  output  8  current byte.
- REQ-008: out_valid  output  1  out_byte is valid.
- REQ-009: out_ready  input  1  consumer accepts out_byte this cycle.
- REQ-010: out_last  output  1  current byte is the final byte of its word.
- REQ-011: out_short  output  1  current word was compressed to one byte (receiver must zero-extend).
- REQ-012: word_count  output  8  number of completed words, modulo 256.

Function
- REQ-013: The block SHALL implement three states: IDLE, SEND_LO, SEND_HI.
- REQ-014: in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in SEND_LO or SEND_HI.
- REQ-015: Input handshake = in_valid && in_ready; on it, in_word SHALL be latched into an internal 16-bit register and the state SHALL move to SEND_LO.
- REQ-016: Short condition SHALL be COMPRESS==1 && latched word[15:8]==8'h00, evaluated once at latch time and held for the word.
- REQ-017: In SEND_LO: out_byte = latched[7:0]; out_last = out_short = short condition.
- REQ-018: In SEND_HI: out_byte = latched[15:8]; out_last = 1; out_short = 0.
- REQ-019: Output handshake = out_valid && out_ready; without it, out_byte, out_last, out_short and state SHALL hold unchanged (out_valid SHALL not drop).
- REQ-020: On output handshake in SEND_LO: short -> IDLE, else -> SEND_HI; in SEND_HI: -> IDLE.
- REQ-021: Byte order SHALL be low byte first, high byte second.
- REQ-022: Latency: first byte valid exactly 1 cycle after input handshake; minimum period 3 cycles per full word, 2 per short word.
- REQ-023: word_count SHALL increment by 1 on the output handshake where out_last==1, wrapping 8'hFF -> 8'h00.
- REQ-024: in_word changes while not in IDLE SHALL have no effect on output.
- REQ-025: Outside SEND_LO/SEND_HI, out_byte, out_last, out_short SHALL be 0.

Reset
- REQ-026: With reset==1 at a rising edge, the state SHALL become IDLE, internal word register 16'h0000, word_count 8'h00; next cycle in_ready=1, out_valid=0, out_byte=8'h00, out_last=0, out_short=0.
- REQ-027: Reset SHALL take priority over any simultaneous handshake; a word in progress SHALL be discarded and not counted.
- REQ-028: The block SHALL accept a new word on the first cycle after reset deasserts.

Verification
- REQ-029: COMPRESS=1, in_word=16'h1234, out_ready=1 -> byte 8'h34 (last=0, short=0), then 8'h12 (last=1, short=0); word_count=1.
- REQ-030: COMPRESS=1, in_word=16'h000F -> single byte 8'h0F with last=1, short=1; in_ready=1 the next cycle; word_count=1.
- REQ-031: COMPRESS=0, in_word=16'h00F0 -> 8'hF0 (last=0), then 8'h00 (last=1, short=0).
- REQ-032: in_word=16'hABCD, out_ready=0 for 3 cycles after out_valid -> out_byte stays 8'hCD, in_ready stays 0; on out_ready=1, 8'hAB follows.
- REQ-033: reset=1 during SEND_HI of 16'h5678 -> out_valid=0 next cycle, word_count=0; a following 16'h0001 (COMPRESS=1) -> 8'h01 short.
- REQ-034: Send 256 full words back-to-back -> word_count wraps to 8'h00; 257th word -> 8'h01.
